// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD arithmetic blocks: digit geometry and FSM state encoding.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_RADIX   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

endpackage

// File: rtl/bcd_fsub_1digit.sv
// One BCD digit of a - b - borrow; purely combinational, zero latency, no flow control.
module bcd_fsub_1digit
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a_i,
    input  logic [BCD_DIGIT_W-1:0] b_i,
    input  logic                   bin_i,
    output logic [BCD_DIGIT_W-1:0] d_o,
    output logic                   bout_o
);

    // Six bits cover the full range -16..15 even for invalid (>9) input digits.
    logic [5:0] t;

    always_comb begin
        t      = {2'b00, a_i} - {2'b00, b_i} - {5'b00000, bin_i};
        bout_o = t[5];
        d_o    = t[5] ? (t[3:0] + BCD_DIGIT_W'(BCD_RADIX)) : t[3:0];
    end

endmodule

// File: rtl/bcd_fsub_serial.sv
// Digit-serial BCD subtractor a - b - bin, NDIGITS cycles from accept to out_valid; results hold while out_ready=0.
// Optional invalid-digit flag built only when BCD_SUB_INVALID_CHECK_EN is defined; otherwise err is tied low.
module bcd_fsub_serial
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NDIGITS*BCD_DIGIT_W-1:0] a,
    input  logic [NDIGITS*BCD_DIGIT_W-1:0] b,
    input  logic                         bin,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NDIGITS*BCD_DIGIT_W-1:0] diff,
    output logic                         bout,
    output logic                         err
);

    localparam int W     = NDIGITS * BCD_DIGIT_W;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    bcd_state_e state_q, state_d;

    logic [W-1:0]             a_q, b_q, acc_q, diff_q;
    logic                     borrow_q, bout_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     accept, last_digit, handoff;
    logic [BCD_DIGIT_W-1:0]   dig;
    logic                     dig_borrow;
    logic [W-1:0]             acc_shift;

    assign accept     = in_valid && (state_q == IDLE);
    assign last_digit = (state_q == BUSY) && (idx_q == LAST_IDX);
    assign handoff    = out_ready && (state_q == DONE);

    bcd_fsub_1digit u_digit (
        .a_i    (a_q[BCD_DIGIT_W-1:0]),
        .b_i    (b_q[BCD_DIGIT_W-1:0]),
        .bin_i  (borrow_q),
        .d_o    (dig),
        .bout_o (dig_borrow)
    );

    // New digit enters at the top so digit 0 ends up in the low nibble after NDIGITS shifts.
    assign acc_shift = W'({dig, acc_q} >> BCD_DIGIT_W);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = BUSY;
            BUSY:    if (last_digit) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else if (accept) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            idx_q    <= '0;
            acc_q    <= '0;
        end else if (state_q == BUSY) begin
            a_q      <= a_q >> BCD_DIGIT_W;
            b_q      <= b_q >> BCD_DIGIT_W;
            borrow_q <= dig_borrow;
            acc_q    <= acc_shift;
            idx_q    <= idx_q + 1'b1;
            if (last_digit) begin
                diff_q <= acc_shift;
                bout_q <= dig_borrow;
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

`ifdef BCD_SUB_INVALID_CHECK_EN
    logic err_q;
    logic any_bad;

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            any_bad = any_bad
                    | (a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9)
                    | (b[i*BCD_DIGIT_W +: BCD_DIGIT_W] > 4'd9);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= any_bad;
        end else if (handoff) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    logic unused_handoff;
    assign unused_handoff = handoff;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_fsub_serial.sv
// Directed self-checking bench for bcd_fsub_serial with NDIGITS=4.
module tb_bcd_fsub_serial;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

`ifdef BCD_SUB_INVALID_CHECK_EN
    localparam logic EXP_INVALID_ERR = 1'b1;
`else
    localparam logic EXP_INVALID_ERR = 1'b0;
`endif

    bcd_fsub_serial #(.NDIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operation, scrambles the inputs afterwards, returns cycles until out_valid (-1 on timeout).
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbin, output int lat);
        int wait_cyc = 0;
        while (!in_ready && wait_cyc < 20) begin
            tick();
            wait_cyc++;
        end
        in_valid = 1'b1;
        a        = ta;
        b        = tb_v;
        bin      = tbin;
        tick();
        in_valid = 1'b0;
        a        = 16'h9898;
        b        = 16'h7777;
        bin      = 1'b1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        vectors++;
        if (diff !== 16'h0000 || bout !== 1'b0) begin miscompares++; $display("FAIL reset_diff got=%h/%b want=0000/0", diff, bout); end
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b want=0", err); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_subtract();
        logic [15:0] va [5]   = '{16'h4321, 16'h0000, 16'h1000, 16'h0000, 16'h9999};
        logic [15:0] vb [5]   = '{16'h1234, 16'h0001, 16'h0001, 16'h0000, 16'h9999};
        logic        vbi[5]   = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
        logic [15:0] vd [5]   = '{16'h3087, 16'h9999, 16'h0998, 16'h9999, 16'h0000};
        logic        vbo[5]   = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b0};
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vbi[i], lat);
            vectors++;
            if (lat !== 4) begin miscompares++; $display("FAIL sub%0d_latency got=%0d want=4", i, lat); end
            vectors++;
            if (diff !== vd[i]) begin miscompares++; $display("FAIL sub%0d_diff got=%h want=%h", i, diff, vd[i]); end
            vectors++;
            if (bout !== vbo[i]) begin miscompares++; $display("FAIL sub%0d_bout got=%b want=%b", i, bout, vbo[i]); end
            vectors++;
            if (err !== 1'b0) begin miscompares++; $display("FAIL sub%0d_err got=%b want=0", i, err); end
            handoff();
            vectors++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL sub%0d_handoff in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_op(16'h4321, 16'h1234, 1'b0, lat);
        // New operands offered while DONE must be ignored.
        in_valid = 1'b1;
        a = 16'h0000; b = 16'h0001; bin = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold%0d_flags out_valid=%b in_ready=%b want 1/0", c, out_valid, in_ready);
            end
            vectors++;
            if (diff !== 16'h3087 || bout !== 1'b0) begin
                miscompares++;
                $display("FAIL hold%0d_result got=%h/%b want=3087/0", c, diff, bout);
            end
            tick();
        end
        in_valid = 1'b0;
        handoff();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        in_valid = 1'b1;
        a = 16'h9999; b = 16'h1111; bin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_flags out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        vectors++;
        if (diff !== 16'h0000 || bout !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs diff=%h bout=%b err=%b want 0000/0/0", diff, bout, err);
        end
        do_op(16'h0005, 16'h0003, 1'b0, lat);
        vectors++;
        if (lat !== 4 || diff !== 16'h0002 || bout !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_next lat=%0d diff=%h bout=%b want 4/0002/0", lat, diff, bout);
        end
        handoff();
    endtask

    task automatic test_invalid_digit();
        int lat;
        do_op(16'h00A0, 16'h0000, 1'b0, lat);
        vectors++;
        if (diff !== 16'h00A0 || bout !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_diff got=%h/%b want=00a0/0", diff, bout);
        end
        vectors++;
        if (err !== EXP_INVALID_ERR) begin
            miscompares++;
            $display("FAIL invalid_err got=%b want=%b", err, EXP_INVALID_ERR);
        end
        handoff();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL invalid_err_clear got=%b want=0", err);
        end
    endtask

    initial begin
        test_reset();
        test_subtract();
        test_backpressure();
        test_reset_midflight();
        test_invalid_digit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation timeout");
    end

endmodule
